note_gate: RTL and testbench

Press-to-gate generator for the piano's note path. It takes the single-cycle press pulses produced by the key-input conditioning stage and turns each one into a timed note-enable level that drives the tone generator and key LED. After every note it enforces a minimum silent gap, and it counts presses it could not serve. It sits between the per-key debounce/edge stage and the tone/audio output stage, one instance per key.

---
 rtl/piano_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/note_gate.sv | 156 +++++++++++++++
 tb/tb_note_gate.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared types and constants for the piano key datapath
//
// Purpose: common definitions used by note_gate and the key-input stages.
//   note_gate_state_t : note_gate FSM states (IDLE, HOLD, GAP)
//   DROP_W            : width of the dropped-press counter
//   TICK_1MS_100MHZ   : clk cycles per 1 ms at 100 MHz (also used by debounce)
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } note_gate_state_t;

  localparam int DROP_W          = 8;
  localparam int TICK_1MS_100MHZ = 100_000;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - timebase divider with synchronous clear
//
// Purpose: counts 0..TICK_DIV-1 and raises tick while the count sits at
// TICK_DIV-1, then wraps. clr forces the count back to 0 on the next edge.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   clr   : synchronous clear of the divider count
//   tick  : high for one cycle out of every TICK_DIV
module tick_prescaler
  import piano_pkg::*;
#(
  parameter int TICK_DIV = TICK_1MS_100MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/note_gate.sv
// rtl/note_gate.sv - press-to-gate note generator with enforced silent gap
//
// Purpose: turns each one-cycle press pulse into a gate level lasting
// HOLD_MS ticks, then holds the gate low for GAP_MS ticks before the next
// press can be served. Presses that cannot be served are counted.
// Build option: NOTE_GATE_RETRIG_EN - when defined, a press during HOLD
// restarts the hold instead of being dropped.
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   trig     : one-cycle press pulse
//   gate     : note enable level (registered)
//   busy     : high whenever the FSM is not IDLE (registered)
//   done     : one-cycle pulse in the first cycle after gate falls normally
//   drop_cnt : saturating count of ignored presses
module note_gate
  import piano_pkg::*;
#(
  parameter int TICK_DIV = TICK_1MS_100MHZ,
  parameter int HOLD_MS  = 200,
  parameter int GAP_MS   = 20,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  output logic              gate,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
  // GAP_MS = 0 never enters GAP; keep the constant in range anyway.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

  note_gate_state_t  r_state;
  note_gate_state_t  w_state_next;
  logic [CNT_W-1:0]  r_tcnt;
  logic              w_tick;
  logic              w_clr;
  logic              w_restart;
  logic              w_done_next;
  logic              w_drop_inc;
  logic              w_hold_to;
  logic              w_gap_to;
  logic              r_gate;
  logic              r_busy;
  logic              r_done;
  logic [DROP_W-1:0] r_drop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_hold_to = w_tick && (r_tcnt == HOLD_LAST);
  assign w_gap_to  = w_tick && (r_tcnt == GAP_LAST);

  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_done_next  = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (trig) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
`ifdef NOTE_GATE_RETRIG_EN
        // A press beats a coincident timeout: the note simply restarts.
        if (trig) begin
          w_restart = 1'b1;
        end else if (w_hold_to) begin
          w_state_next = (GAP_MS == 0) ? IDLE : GAP;
          w_done_next  = 1'b1;
        end
`else
        if (w_hold_to) begin
          w_state_next = (GAP_MS == 0) ? IDLE : GAP;
          w_done_next  = 1'b1;
        end
        if (trig) begin
          w_drop_inc = 1'b1;
        end
`endif
      end
      GAP: begin
        if (trig) begin
          w_drop_inc = 1'b1;
        end
        if (w_gap_to) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Timebase restarts on every state entry (and restart) so each duration
  // is an exact multiple of TICK_DIV regardless of when the press arrived.
  assign w_clr = (r_state == IDLE) || (w_state_next != r_state) || w_restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (w_clr) begin
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_gate <= (w_state_next == HOLD);
      r_busy <= (w_state_next != IDLE);
      r_done <= w_done_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_drop_inc && (r_drop != {DROP_W{1'b1}})) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign gate     = r_gate;
  assign busy     = r_busy;
  assign done     = r_done;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_note_gate.sv
// tb/tb_note_gate.sv - directed vector bench for note_gate
module tb_note_gate;

  logic       clk;
  logic       reset;
  logic       trig;
  logic       gate;
  logic       busy;
  logic       done;
  logic [7:0] drop_cnt;

  int n_total;
  int n_pass;
  int cyc;

  note_gate #(
    .TICK_DIV(4),
    .HOLD_MS (3),
    .GAP_MS  (2),
    .CNT_W   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trig    (trig),
    .gate    (gate),
    .busy    (busy),
    .done    (done),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rst: apply reset first and restart cycle numbering at 0
  // cyc: cycle at which trig is driven and outputs are checked
  typedef struct {
    bit rst;
    int cyc;
    bit trig;
    bit gate;
    bit busy;
    bit done;
    int drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit rst, int c, bit t, bit g, bit b, bit d, int dr);
    vec_t r;
    r.rst  = rst;
    r.cyc  = c;
    r.trig = t;
    r.gate = g;
    r.busy = b;
    r.done = d;
    r.drop = dr;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Next cycle begins 1 time unit after the rising edge.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    trig = 1'b0;
  endtask

  task automatic apply_reset();
    trig = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int prev;
    bit mono;
    n_total = 0;
    n_pass  = 0;
    cyc     = 0;
    reset   = 1'b1;
    trig    = 1'b0;

    // Single note with GAP drops, a GAP-timeout drop and the earliest retrigger.
    vecs.push_back(v(1,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 10, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 11, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 22, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 23, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 24, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 25, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 26, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 30, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 31, 1, 0, 0, 0, 2));
    vecs.push_back(v(0, 32, 0, 1, 1, 0, 2));
    // Press during HOLD at cycle 18.
    vecs.push_back(v(1, 10, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 18, 1, 1, 1, 0, 0));
`ifdef NOTE_GATE_RETRIG_EN
    vecs.push_back(v(0, 19, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 23, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 30, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 31, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 39, 0, 0, 0, 0, 0));
`else
    vecs.push_back(v(0, 19, 0, 1, 1, 0, 1));
    vecs.push_back(v(0, 22, 0, 1, 1, 0, 1));
    vecs.push_back(v(0, 23, 0, 0, 1, 1, 1));
    vecs.push_back(v(0, 31, 0, 0, 0, 0, 1));
`endif
    // Press coincident with the HOLD timeout (cycle 22).
    vecs.push_back(v(1, 10, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 22, 1, 1, 1, 0, 0));
`ifdef NOTE_GATE_RETRIG_EN
    vecs.push_back(v(0, 23, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 34, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 35, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 43, 0, 0, 0, 0, 0));
`else
    vecs.push_back(v(0, 23, 0, 0, 1, 1, 1));
    vecs.push_back(v(0, 30, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 31, 0, 0, 0, 0, 1));
`endif

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      while (cyc < vecs[i].cyc) advance();
      trig = vecs[i].trig;
      #4;
      chk($sformatf("v%0d c%0d gate", i, cyc), int'(gate), int'(vecs[i].gate));
      chk($sformatf("v%0d c%0d busy", i, cyc), int'(busy), int'(vecs[i].busy));
      chk($sformatf("v%0d c%0d done", i, cyc), int'(done), int'(vecs[i].done));
      chk($sformatf("v%0d c%0d drop", i, cyc), int'(drop_cnt), vecs[i].drop);
    end

    // Asynchronous reset in the middle of HOLD.
    apply_reset();
    while (cyc < 10) advance();
    trig = 1'b1;
    while (cyc < 12) advance();
    trig = 1'b1;
    while (cyc < 14) advance();
    #4;
    chk("pre_rst gate", int'(gate), 1);
`ifdef NOTE_GATE_RETRIG_EN
    chk("pre_rst drop", int'(drop_cnt), 0);
`else
    chk("pre_rst drop", int'(drop_cnt), 1);
`endif
    advance();
    reset = 1'b1;
    #1;
    chk("async_rst gate", int'(gate), 0);
    chk("async_rst busy", int'(busy), 0);
    chk("async_rst drop", int'(drop_cnt), 0);
    #1;
    reset = 1'b0;
    while (cyc < 20) advance();
    trig = 1'b1;
    #4;
    chk("post_rst c20 gate", int'(gate), 0);
    advance();
    #4;
    chk("post_rst c21 gate", int'(gate), 1);
    chk("post_rst c21 busy", int'(busy), 1);

    // 300 presses, one every other cycle.
    apply_reset();
    prev = 0;
    mono = 1'b1;
    for (int k = 0; k < 300; k++) begin
      advance();
      trig = 1'b1;
      #4;
      if (int'(drop_cnt) < prev) mono = 1'b0;
      prev = int'(drop_cnt);
      advance();
      #4;
      if (int'(drop_cnt) < prev) mono = 1'b0;
      prev = int'(drop_cnt);
    end
    advance();
    #4;
    chk("sat monotonic", int'(mono), 1);
`ifdef NOTE_GATE_RETRIG_EN
    chk("sat drop", int'(drop_cnt), 0);
    chk("sat gate", int'(gate), 1);
`else
    chk("sat drop", int'(drop_cnt), 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
